// File: rtl/spi_burst_control_unit.sv
// SPI frame decoder: one opcode byte, ADDR_BYTES address bytes (MSB first), then data bytes.
// Define SPI_BURST_EN to support burst opcodes 0x02/0x03 and build the address incrementer.
module spi_burst_control_unit #(
  parameter int ADDR_BYTES = 2,
  parameter int NUM_REGS   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cs,
  input  logic                    data_valid,
  input  logic [7:0]              rx_byte,
  input  logic [NUM_REGS-1:0]     reg_ready_clear,
  output logic                    instr_reg_en,
  output logic [ADDR_BYTES-1:0]   addr_byte_en,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic                    write_memory_enable,
  output logic                    read_memory_request,
  output logic [NUM_REGS-1:0]     reg_ready_en,
  output logic [NUM_REGS-1:0]     reg_ready,
  output logic                    spi_instruction_done,
  output logic                    frame_abort,
  output logic                    illegal_instr
);

  localparam int AW = 8 * ADDR_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_INSTR, S_ADDR, S_DATA, S_IGNORE} state_e;

  state_e              state_q;
  logic [7:0]          opcode_q;
  logic [2:0]          addr_cnt_q;
  logic                data_seen_q;
  logic [AW-1:0]       mem_addr_q;
  logic [NUM_REGS-1:0] reg_ready_q;
  logic                read_req_q;
  logic                done_q;
  logic                abort_q;
  logic                illegal_q;

  logic                dv_act;
  logic                op_is_read;
  logic                op_wr_single;
  logic                op_wr_burst;
  logic                op_rd_burst;
  logic                last_addr;
  logic                frame_complete;
  logic [AW-1:0]       addr_shift_d;
  logic [NUM_REGS-1:0] reg_sel;

  function automatic logic is_reg_op(input logic [7:0] op);
    is_reg_op = 1'b0;
    for (int k = 0; k < NUM_REGS; k++)
      if (op == 8'(5 + 2 * k)) is_reg_op = 1'b1;
  endfunction

  function automatic logic is_legal_op(input logic [7:0] op);
`ifdef SPI_BURST_EN
    is_legal_op = (op <= 8'h03) || is_reg_op(op);
`else
    is_legal_op = (op <= 8'h01) || is_reg_op(op);
`endif
  endfunction

  assign dv_act = data_valid && !cs;

  always_comb begin
    op_wr_single = (opcode_q == 8'h01);
`ifdef SPI_BURST_EN
    op_rd_burst  = (opcode_q == 8'h02);
    op_wr_burst  = (opcode_q == 8'h03);
`else
    op_rd_burst  = 1'b0;
    op_wr_burst  = 1'b0;
`endif
    op_is_read   = (opcode_q == 8'h00) || op_rd_burst;
    last_addr    = (addr_cnt_q == 3'(ADDR_BYTES - 1));
    addr_shift_d = (mem_addr_q << 8) | AW'(rx_byte);
    // Reads are complete once the address is in; writes need at least one data byte.
    frame_complete = (state_q == S_DATA) && (op_is_read || data_seen_q);
    for (int k = 0; k < NUM_REGS; k++)
      reg_sel[k] = (opcode_q == 8'(5 + 2 * k));
  end

  always_comb begin
    instr_reg_en = dv_act && (state_q == S_INSTR);
    for (int i = 0; i < ADDR_BYTES; i++)
      addr_byte_en[i] = dv_act && (state_q == S_ADDR) && (addr_cnt_q == 3'(ADDR_BYTES - 1 - i));
    write_memory_enable = dv_act && (state_q == S_DATA) &&
                          ((op_wr_single && !data_seen_q) || op_wr_burst);
    reg_ready_en = (dv_act && (state_q == S_DATA) && !data_seen_q) ? reg_sel : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      opcode_q    <= 8'h00;
      addr_cnt_q  <= 3'd0;
      data_seen_q <= 1'b0;
      mem_addr_q  <= '0;
      reg_ready_q <= '0;
      read_req_q  <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      read_req_q  <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      illegal_q   <= 1'b0;
      reg_ready_q <= (reg_ready_q & ~reg_ready_clear) | reg_ready_en;
      if (cs) begin
        if (state_q != S_IDLE) begin
          done_q  <= frame_complete;
          abort_q <= !frame_complete && (state_q != S_IGNORE);
        end
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q     <= S_INSTR;
            addr_cnt_q  <= 3'd0;
            data_seen_q <= 1'b0;
          end
          S_INSTR: begin
            if (data_valid) begin
              opcode_q <= rx_byte;
              if (is_legal_op(rx_byte)) begin
                state_q <= S_ADDR;
              end else begin
                state_q   <= S_IGNORE;
                illegal_q <= 1'b1;
              end
            end
          end
          S_ADDR: begin
            if (data_valid) begin
              mem_addr_q <= addr_shift_d;
              addr_cnt_q <= addr_cnt_q + 3'd1;
              if (last_addr) begin
                state_q    <= S_DATA;
                read_req_q <= op_is_read;
              end
            end
          end
          S_DATA: begin
            if (data_valid) begin
              data_seen_q <= 1'b1;
`ifdef SPI_BURST_EN
              if (op_rd_burst || op_wr_burst) mem_addr_q <= mem_addr_q + AW'(1);
              if (op_rd_burst) read_req_q <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_addr             = mem_addr_q;
  assign reg_ready            = reg_ready_q;
  assign read_memory_request  = read_req_q;
  assign spi_instruction_done = done_q;
  assign frame_abort          = abort_q;
  assign illegal_instr        = illegal_q;

endmodule

// File: tb/tb_spi_burst_control_unit.sv
// Directed bench for spi_burst_control_unit (ADDR_BYTES=2, NUM_REGS=3).
module tb_spi_burst_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        data_valid;
  logic [7:0]  rx_byte;
  logic [2:0]  reg_ready_clear;
  logic        instr_reg_en;
  logic [1:0]  addr_byte_en;
  logic [15:0] mem_addr;
  logic        write_memory_enable;
  logic        read_memory_request;
  logic [2:0]  reg_ready_en;
  logic [2:0]  reg_ready;
  logic        spi_instruction_done;
  logic        frame_abort;
  logic        illegal_instr;

  int n_cmp = 0;
  int n_err = 0;

  spi_burst_control_unit #(.ADDR_BYTES(2), .NUM_REGS(3)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .data_valid(data_valid), .rx_byte(rx_byte),
    .reg_ready_clear(reg_ready_clear), .instr_reg_en(instr_reg_en),
    .addr_byte_en(addr_byte_en), .mem_addr(mem_addr),
    .write_memory_enable(write_memory_enable), .read_memory_request(read_memory_request),
    .reg_ready_en(reg_ready_en), .reg_ready(reg_ready),
    .spi_instruction_done(spi_instruction_done), .frame_abort(frame_abort),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; drop data_valid afterwards.
  task automatic clk1();
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    data_valid = 1'b1;
    rx_byte    = b;
    #1;
  endtask

  task automatic start();
    cs = 1'b0;
    clk1();
  endtask

  task automatic close_frame(input string tag, input logic exp_done, input logic exp_abort);
    cs = 1'b1;
    clk1();
    chk({tag, "_done"}, spi_instruction_done, exp_done);
    chk({tag, "_abort"}, frame_abort, exp_abort);
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b1; data_valid = 1'b0; rx_byte = 8'h00; reg_ready_clear = 3'b000;
    clk1(); clk1();
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_reg_ready", reg_ready, 3'b000);
    chk("rst_pulses", {read_memory_request, spi_instruction_done, frame_abort, illegal_instr}, 4'b0000);
    reset_n = 1'b1;
    clk1();

    // Write single
    start();
    put(8'h01); chk("ws_instr_en", instr_reg_en, 1'b1); clk1();
    put(8'h12); chk("ws_addr_en_msb", addr_byte_en, 2'b10); clk1();
    put(8'h34); chk("ws_addr_en_lsb", addr_byte_en, 2'b01); clk1();
    chk("ws_mem_addr", mem_addr, 16'h1234);
    chk("ws_no_rdreq", read_memory_request, 1'b0);
    put(8'hAB); chk("ws_we", write_memory_enable, 1'b1);
    chk("ws_we_addr", mem_addr, 16'h1234); chk("ws_we_data", rx_byte, 8'hAB); clk1();
    put(8'hCD); chk("ws_we_second", write_memory_enable, 1'b0); clk1();
    close_frame("ws", 1'b1, 1'b0);
    clk1();
    chk("ws_done_pulse_end", spi_instruction_done, 1'b0);

    // Read single
    start();
    put(8'h00); clk1(); put(8'h00); clk1(); put(8'h20); clk1();
    chk("rs_req", read_memory_request, 1'b1);
    chk("rs_addr", mem_addr, 16'h0020);
    put(8'h55); clk1();
    chk("rs_req_once", read_memory_request, 1'b0);
    chk("rs_addr_hold", mem_addr, 16'h0020);
    close_frame("rs", 1'b1, 1'b0);

`ifdef SPI_BURST_EN
    // Write burst with wrap
    start();
    put(8'h03); clk1(); put(8'hFF); clk1(); put(8'hFE); clk1();
    put(8'h10); chk("wb_we0", write_memory_enable, 1'b1); chk("wb_a0", mem_addr, 16'hFFFE); clk1();
    put(8'h11); chk("wb_we1", write_memory_enable, 1'b1); chk("wb_a1", mem_addr, 16'hFFFF); clk1();
    put(8'h12); chk("wb_we2", write_memory_enable, 1'b1); chk("wb_a2", mem_addr, 16'h0000); clk1();
    put(8'h13); chk("wb_we3", write_memory_enable, 1'b1); chk("wb_a3", mem_addr, 16'h0001); clk1();
    close_frame("wb", 1'b1, 1'b0);

    // Read burst
    start();
    put(8'h02); clk1(); put(8'h00); clk1(); put(8'h10); clk1();
    chk("rb_req0", read_memory_request, 1'b1); chk("rb_a0", mem_addr, 16'h0010);
    clk1();
    chk("rb_gap", read_memory_request, 1'b0);
    put(8'h00); clk1();
    chk("rb_req1", read_memory_request, 1'b1); chk("rb_a1", mem_addr, 16'h0011);
    put(8'h00); clk1();
    chk("rb_req2", read_memory_request, 1'b1); chk("rb_a2", mem_addr, 16'h0012);
    close_frame("rb", 1'b1, 1'b0);
`else
    // Burst opcode rejected in the default build
    start();
    put(8'h03); clk1();
    chk("nb_illegal", illegal_instr, 1'b1);
    put(8'hFF); chk("nb_no_addr_en", addr_byte_en, 2'b00); clk1();
    chk("nb_illegal_pulse", illegal_instr, 1'b0);
    put(8'h77); chk("nb_no_we", write_memory_enable, 1'b0); clk1();
    close_frame("nb", 1'b0, 1'b0);
    chk("nb_addr_kept", mem_addr, 16'h0020);
`endif

    // Register writes 0x05 / 0x07 / 0x09
    start();
    put(8'h05); clk1(); put(8'h00); clk1(); put(8'h00); clk1();
    put(8'h5A); chk("r0_en", reg_ready_en, 3'b001); chk("r0_no_we", write_memory_enable, 1'b0); clk1();
    chk("r0_ready", reg_ready, 3'b001);
    put(8'h5B); chk("r0_en_second", reg_ready_en, 3'b000); clk1();
    close_frame("r0", 1'b1, 1'b0);
    start();
    put(8'h07); clk1(); put(8'h00); clk1(); put(8'h00); clk1();
    put(8'h5A); chk("r1_en", reg_ready_en, 3'b010); clk1();
    close_frame("r1", 1'b1, 1'b0);
    start();
    put(8'h09); clk1(); put(8'h00); clk1(); put(8'h00); clk1();
    put(8'h5A); chk("r2_en", reg_ready_en, 3'b100); clk1();
    chk("r2_ready", reg_ready, 3'b111);
    close_frame("r2", 1'b1, 1'b0);
    reg_ready_clear = 3'b010; clk1(); reg_ready_clear = 3'b000;
    chk("clr_ready", reg_ready, 3'b101);
    start();
    put(8'h07); clk1(); put(8'h00); clk1(); put(8'h00); clk1();
    put(8'h5A); reg_ready_clear = 3'b010; clk1(); reg_ready_clear = 3'b000;
    chk("set_wins", reg_ready, 3'b111);
    close_frame("r1b", 1'b1, 1'b0);

    // Illegal opcode
    start();
    put(8'h0B); chk("il_instr_en", instr_reg_en, 1'b1); clk1();
    chk("il_pulse", illegal_instr, 1'b1);
    put(8'h01); chk("il_no_strobe", {write_memory_enable, addr_byte_en, reg_ready_en}, 6'b0); clk1();
    chk("il_pulse_end", illegal_instr, 1'b0);
    close_frame("il", 1'b0, 1'b0);

    // Abort after partial address
    start();
    put(8'h01); clk1(); put(8'h12); clk1();
    close_frame("ab", 1'b0, 1'b1);
    clk1();
    chk("idle_rise", {spi_instruction_done, frame_abort}, 2'b00);

    // Reset mid-frame
    start();
    put(8'h01); clk1(); put(8'h56); clk1(); put(8'h78); clk1();
    put(8'h99); chk("mr_we_before", write_memory_enable, 1'b1);
    reset_n = 1'b0; #1;
    chk("mr_we", write_memory_enable, 1'b0);
    chk("mr_addr", mem_addr, 16'h0000);
    chk("mr_ready", reg_ready, 3'b000);
    data_valid = 1'b0;
    clk1();
    reset_n = 1'b1; cs = 1'b1;
    clk1();
    chk("mr_no_pulse", {spi_instruction_done, frame_abort, illegal_instr, read_memory_request}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_burst_control_unit.md
# spi_burst_control_unit

Parametrised successor of the SPI frame control unit. Sits between the SPI byte deserialiser and the memory/configuration register file. Decodes a frame of one instruction byte, `ADDR_BYTES` address bytes and N data bytes, and generates capture enables, memory read/write strobes and per-register ready flags. Compared with the fixed 4-byte frame decoder it adds configurable address width, N configuration-register targets, burst transfers with address auto-increment, and illegal-opcode/abort reporting.

## Interface
Parameters:
- `ADDR_BYTES`, 2: number of address bytes per frame (1..4), MSB first.
- `NUM_REGS`, 3: number of configuration-register write targets (1..8).

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs` in 1: SPI chip select, active low, synchronous to `clk`.
- `data_valid` in 1: one-cycle pulse per completed SPI byte.
- `rx_byte` in 8: received byte, valid while `data_valid`=1.
- `reg_ready_clear` in NUM_REGS: per-register acknowledge pulse from the consumer.
- `instr_reg_en` out 1: capture enable for the instruction byte.
- `addr_byte_en` out ADDR_BYTES: one-hot capture enable, bit ADDR_BYTES-1 = first (MSB) address byte.
- `mem_addr` out 8*ADDR_BYTES: current memory address.
- `write_memory_enable` out 1: memory write strobe; data = `rx_byte`.
- `read_memory_request` out 1: memory read strobe at `mem_addr`.
- `reg_ready_en` out NUM_REGS: pulse with the data byte of a register write.
- `reg_ready` out NUM_REGS: sticky ready flags.
- `spi_instruction_done` out 1: frame completed pulse.
- `frame_abort` out 1: frame ended early pulse.
- `illegal_instr` out 1: unsupported opcode pulse.

## Operation
- Opcodes: 0x00 read single; 0x01 write single; 0x02 read burst; 0x03 write burst; 0x05+2k register write k, for k < NUM_REGS. Everything else is illegal.
- States and transitions:
  - IDLE → INSTR when `cs`=0.
  - INSTR → ADDR on `data_valid`, or → IGNORE if the opcode is illegal.
  - ADDR → DATA after ADDR_BYTES bytes.
  - DATA → DATA on each further byte.
  - IGNORE → IGNORE until `cs` rises.
  - Any state with `cs`=1 → IDLE on the next edge.
- `data_valid` is ignored while `cs`=1 or in IGNORE.
- Address bytes shift into the internal address register, MSB first. `mem_addr` holds the full address from the cycle after the last address byte.
- Write single (0x01): first data byte strobes `write_memory_enable`; later bytes are ignored.
- Write burst (0x03): every data byte strobes a write; `mem_addr` increments after each strobe, wrapping from all-ones to 0.
- Read single (0x00): exactly one `read_memory_request`, one cycle after the last address byte.
- Read burst (0x02): first request as for read single; each data byte (byte shifted out) increments `mem_addr` and issues the next request one cycle later.
- Register write k: address bytes are captured but ignored. The first data byte pulses `reg_ready_en[k]` and sets `reg_ready[k]`; later bytes are ignored.
- `reg_ready[k]` is cleared by `reg_ready_clear[k]`; a simultaneous set wins.
- On `cs` rise:
  - Frame complete (writes/register writes: at least one data byte; reads: all address bytes) → `spi_instruction_done`.
  - Any other frame not already in IGNORE → `frame_abort`.
  - Rising in IDLE → neither.

## Timing
- Reset values: state IDLE, `mem_addr`=0, `reg_ready`=0, every pulse output 0.
- `instr_reg_en`, `addr_byte_en`, `write_memory_enable` and `reg_ready_en` are combinational (Mealy) and high in the same cycle as the qualifying `data_valid`.
- `mem_addr` is stable during a write strobe; the burst increment is visible the following cycle.
- `read_memory_request`, `spi_instruction_done`, `frame_abort` and `illegal_instr` are registered one-cycle pulses.
  - `illegal_instr` fires the cycle after the offending byte.
  - done/abort fire the cycle after `cs` is sampled high.
- Back-to-back frames: `cs` may fall again the cycle after it rose; the new frame starts in INSTR.
- `reset_n` low mid-frame: immediate return to reset values, no done/abort pulse.

## Configuration
- `SPI_BURST_EN` defined: opcodes 0x02/0x03 are supported and the address incrementer is built.
- `SPI_BURST_EN` undefined: 0x02/0x03 decode as illegal (`illegal_instr` pulse, frame goes to IGNORE) and no incrementer is built. `mem_addr` changes only via address bytes.

## Test plan
- Write single, ADDR_BYTES=2: frame 0x01, 0x12, 0x34, 0xAB → `addr_byte_en`=10 then 01, one write strobe with `mem_addr`=0x1234 and `rx_byte`=0xAB; done one cycle after `cs` rises.
- Write burst: 0x03, 0xFF, 0xFE, then 4 data bytes → 4 strobes at 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
- Read burst: 0x02, 0x00, 0x10, then 2 bytes → requests at 0x0010, 0x0011, 0x0012.
- Register writes 0x05/0x07/0x09 (NUM_REGS=3), each with one data byte → `reg_ready_en` = 001/010/100 and `reg_ready`=111. Then `reg_ready_clear`=010 → 101; clear coinciding with a set keeps the bit 1.
- Opcode 0x0B, then `cs` rise → `illegal_instr` pulse, no strobes, no done/abort. Frame 0x01, 0x12, then `cs` rise → `frame_abort`, no write.
- Build without `SPI_BURST_EN`: opcode 0x03 → `illegal_instr`, no writes. Then `reset_n` pulled low mid-frame → all outputs 0 immediately.
